// File: rtl/alu_seq_top.sv
// Sequential ALU top: edge-triggered operand/opcode loading from a shared bus,
// one-cycle execute with registered result, flags and optional accumulator chaining.
module alu_seq_top #(
  parameter int NB_DATA  = 8,
  parameter int NB_OP    = 6,
  parameter int NB_SHAMT = $clog2(NB_DATA)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_enable_1,
  input  logic               i_enable_2,
  input  logic               i_enable_3,
  input  logic               i_chain,
  output logic [NB_DATA-1:0] o_led_data,
  output logic               o_led_carry,
  output logic               o_led_zero,
  output logic               o_led_overflow,
  output logic               o_led_error,
  output logic               o_valid,
  output logic [2:0]         o_loaded
);

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);

  typedef enum logic {COLLECT, EXEC} state_t;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] res_q, res_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic               valid_q, valid_d;
  logic [2:0]         mask_q, mask_d;
  logic [2:0]         prev_q, prev_d;

  logic [2:0]          en, rise;
  logic [NB_DATA:0]    sum_add, sum_sub;
  logic [NB_DATA-1:0]  alu_r;
  logic                alu_c, alu_v, alu_e;
  logic [NB_SHAMT-1:0] shamt;
  logic                sa, sb, sr;

  assign en    = {i_enable_3, i_enable_2, i_enable_1};
  assign rise  = en & ~prev_q;
  assign shamt = b_q[NB_SHAMT-1:0];
  assign sa    = a_q[NB_DATA-1];
  assign sb    = b_q[NB_DATA-1];
  assign sr    = alu_r[NB_DATA-1];

  always_comb begin
    sum_add = {1'b0, a_q} + {1'b0, b_q};
    sum_sub = {1'b0, a_q} + {1'b0, ~b_q} + {{NB_DATA{1'b0}}, 1'b1};
    alu_r   = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_e   = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_r = sum_add[NB_DATA-1:0];
        alu_c = sum_add[NB_DATA];
        alu_v = (sa == sb) && (sr != sa);
      end
      OP_SUB: begin
        alu_r = sum_sub[NB_DATA-1:0];
        alu_c = sum_sub[NB_DATA];
        alu_v = (sa != sb) && (sr != sa);
      end
      OP_AND:  alu_r = a_q & b_q;
      OP_OR:   alu_r = a_q | b_q;
      OP_XOR:  alu_r = a_q ^ b_q;
      OP_NOR:  alu_r = ~(a_q | b_q);
      OP_SRL:  alu_r = a_q >> shamt;
      OP_SRA:  alu_r = $unsigned($signed(a_q) >>> shamt);
      default: alu_e = 1'b1;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    valid_d = 1'b0;
    prev_d  = en;
    mask_d  = mask_q | rise;
    if (state_q == EXEC) begin
      res_d   = alu_r;
      carry_d = alu_c;
      zero_d  = (alu_r == '0);
      ovf_d   = alu_v;
      err_d   = alu_e;
      valid_d = 1'b1;
      mask_d  = {2'b00, i_chain} | rise;
      if (i_chain) a_d = alu_r;
    end
    // A fresh load edge takes priority over the chained write-back
    if (rise[0]) a_d = i_data;
    if (rise[1]) b_d = i_data;
    if (rise[2]) op_d = i_data[NB_DATA-1 -: NB_OP];
    state_d = (mask_d == 3'b111) ? EXEC : COLLECT;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= COLLECT;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      mask_q  <= 3'b000;
      prev_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      mask_q  <= mask_d;
      prev_q  <= prev_d;
    end
  end

  assign o_led_data     = res_q;
  assign o_led_carry    = carry_q;
  assign o_led_zero     = zero_q;
  assign o_led_overflow = ovf_q;
  assign o_led_error    = err_q;
  assign o_valid        = valid_q;
  assign o_loaded       = mask_q;

endmodule

// File: tb/tb_alu_seq_top.sv
// Scoreboard bench for alu_seq_top: 8-bit and 16-bit instances,
// directed vectors, expected results queued at issue and checked on o_valid.
module tb_alu_seq_top;

  typedef struct {
    logic [15:0] d;
    logic        c, z, v, e;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  d8 = '0;
  logic        a1 = 0, a2 = 0, a3 = 0, ch8 = 0;
  logic [7:0]  r8;
  logic        c8, z8, v8, e8, ok8;
  logic [2:0]  l8;

  logic [15:0] d16 = '0;
  logic        b1 = 0, b2 = 0, b3 = 0, ch16 = 0;
  logic [15:0] r16;
  logic        c16, z16, v16, e16, ok16;
  logic [2:0]  l16;

  int checks = 0;
  int errors = 0;
  exp_t q8[$];
  exp_t q16[$];

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] ANDO = 6'b100100;
  localparam logic [5:0] ORO = 6'b100101;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] BAD = 6'b111111;

  alu_seq_top #(.NB_DATA(8)) dut8 (
    .i_clk(clk), .i_reset(rst), .i_data(d8),
    .i_enable_1(a1), .i_enable_2(a2), .i_enable_3(a3),
    .i_chain(ch8), .o_led_data(r8), .o_led_carry(c8),
    .o_led_zero(z8), .o_led_overflow(v8), .o_led_error(e8),
    .o_valid(ok8), .o_loaded(l8)
  );

  alu_seq_top #(.NB_DATA(16)) dut16 (
    .i_clk(clk), .i_reset(rst), .i_data(d16),
    .i_enable_1(b1), .i_enable_2(b2), .i_enable_3(b3),
    .i_chain(ch16), .o_led_data(r16), .o_led_carry(c16),
    .o_led_zero(z16), .o_led_overflow(v16), .o_led_error(e16),
    .o_valid(ok16), .o_loaded(l16)
  );

  function automatic exp_t mk(logic [15:0] d, logic c, logic z,
                              logic v, logic e);
    exp_t x;
    x.d = d; x.c = c; x.z = z; x.v = v; x.e = e;
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // monitor: pops one expectation per o_valid pulse
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (ok8 === 1'b1) begin
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL mon8 unexpected valid data=%0h", r8);
        end else begin
          x = q8.pop_front();
          if ({r8, c8, z8, v8, e8} !== {x.d[7:0], x.c, x.z, x.v, x.e}) begin
            errors++;
            $display("FAIL mon8 actual d=%0h c%0b z%0b v%0b e%0b required d=%0h c%0b z%0b v%0b e%0b",
                     r8, c8, z8, v8, e8, x.d[7:0], x.c, x.z, x.v, x.e);
          end
        end
      end
      if (ok16 === 1'b1) begin
        checks++;
        if (q16.size() == 0) begin
          errors++;
          $display("FAIL mon16 unexpected valid data=%0h", r16);
        end else begin
          x = q16.pop_front();
          if ({r16, c16, z16, v16, e16} !== {x.d, x.c, x.z, x.v, x.e}) begin
            errors++;
            $display("FAIL mon16 actual d=%0h c%0b z%0b v%0b e%0b required d=%0h c%0b z%0b v%0b e%0b",
                     r16, c16, z16, v16, e16, x.d, x.c, x.z, x.v, x.e);
          end
        end
      end
    end
  end

  task automatic drv(input bit s16, input logic [2:0] en,
                     input logic [15:0] d);
    if (s16) begin
      d16 = d; {b3, b2, b1} = en;
    end else begin
      d8 = d[7:0]; {a3, a2, a1} = en;
    end
    @(negedge clk);
    {b3, b2, b1} = 3'b000;
    {a3, a2, a1} = 3'b000;
  endtask

  task automatic run_op(input bit s16, input logic [5:0] op, input exp_t x);
    logic [15:0] od;
    od = s16 ? {op, 10'b0} : {8'b0, op, 2'b00};
    if (s16) q16.push_back(x); else q8.push_back(x);
    drv(s16, 3'b100, od);
    chk("valid_early", s16 ? ok16 : ok8, 0);
    @(negedge clk);
    chk("valid_pulse", s16 ? ok16 : ok8, 1);
    @(negedge clk);
    chk("valid_drop", s16 ? ok16 : ok8, 0);
  endtask

  task automatic ab_op(input bit s16, input logic [15:0] a,
                       input logic [15:0] b, input logic [5:0] op,
                       input exp_t x);
    drv(s16, 3'b001, a);
    drv(s16, 3'b010, b);
    run_op(s16, op, x);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_data", r8, 0);
    chk("rst_flags", {c8, z8, v8, e8, ok8}, 0);
    chk("rst_mask", l8, 0);
    rst = 1'b0;
    @(negedge clk);

    drv(0, 3'b001, 16'd15);
    drv(0, 3'b010, 16'd10);
    chk("mask_ab", l8, 3'b011);
    run_op(0, ADD, mk(16'd25, 0, 0, 0, 0));
    chk("mask_clr", l8, 3'b000);
    ab_op(0, 16'd200, 16'd100, ADD, mk(16'd44, 1, 0, 0, 0));
    ab_op(0, 16'd128, 16'd128, ADD, mk(16'd0, 1, 1, 1, 0));
    ab_op(0, 16'h05, 16'h07, SUB, mk(16'hFE, 0, 0, 0, 0));
    ab_op(0, 16'h80, 16'h01, SUB, mk(16'h7F, 1, 0, 1, 0));
    ab_op(0, 16'hAA, 16'h55, ANDO, mk(16'h00, 0, 1, 0, 0));

    a1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d8 = 8'h33 + 8'(i * 17);
      @(negedge clk);
    end
    a1 = 1'b0;
    chk("hold_mask", l8, 3'b001);
    drv(0, 3'b010, 16'h00);
    run_op(0, ADD, mk(16'h33, 0, 0, 0, 0));

    ab_op(0, 16'h12, 16'h34, BAD, mk(16'h00, 0, 1, 0, 1));
    ab_op(0, 16'h0F, 16'hF0, ORO, mk(16'hFF, 0, 0, 0, 0));

    ch8 = 1'b1;
    ab_op(0, 16'd1, 16'd1, ADD, mk(16'd2, 0, 0, 0, 0));
    chk("chain_mask", l8, 3'b001);
    for (int k = 3; k <= 5; k++) begin
      drv(0, 3'b010, 16'd1);
      run_op(0, ADD, mk(16'(k), 0, 0, 0, 0));
    end
    ch8 = 1'b0;

    drv(0, 3'b010, 16'd2);
    d8 = {ADD, 2'b00};
    a3 = 1'b1;
    @(negedge clk);
    a3 = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_data", r8, 0);
    chk("arst_flags", {c8, z8, v8, e8, ok8}, 0);
    chk("arst_mask", l8, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_novalid", ok8, 0);
    end
    chk("arst_hold", {r8, l8}, 0);

    ab_op(1, 16'hFFFF, 16'h0001, ADD, mk(16'h0000, 1, 1, 0, 0));
    ab_op(1, 16'h8000, 16'h0004, SRA, mk(16'hF800, 0, 0, 0, 0));

    repeat (3) @(negedge clk);
    chk("q8_empty", q8.size(), 0);
    chk("q16_empty", q16.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
